// File: rtl/pause_sched.sv
// Frame-aligned pause scheduler: merges the OS menu flag with module pause requests and
// moves the core into and out of pause only on a vblank rising edge (or after a timeout).
module pause_sched #(
    parameter int NUM_REQ       = 4,
    parameter int TIMEOUT_CYC   = 1_000_000,
    parameter int MIN_PAUSE_CYC = 16
) (
    input  logic               clk_sys_i,
    input  logic               reset_i,
    input  logic               os_inmenu_i,
    input  logic               vblank_i,
    input  logic [NUM_REQ-1:0] pause_req_i,
    output logic               pause_core_o,
    output logic [NUM_REQ-1:0] pause_ack_o,
    output logic [1:0]         pause_state_o
);

    localparam int WW = $clog2(TIMEOUT_CYC);
    localparam int HW = $clog2(MIN_PAUSE_CYC + 1);
    localparam logic [WW-1:0] WCNT_MAX = WW'(TIMEOUT_CYC - 1);
    localparam logic [HW-1:0] HCNT_MAX = HW'(MIN_PAUSE_CYC);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ARM     = 2'd1,
        PAUSED  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 inmenuMeta_q, inmenuSync_q;
    logic                 vblank_q;
    logic [WW-1:0]        wcnt_q, wcnt_d;
    logic [HW-1:0]        hcnt_q, hcnt_d;
    logic                 pauseCore_q;
    logic [NUM_REQ-1:0]   pauseAck_q;

    logic anyReq, vbRise, timeoutHit, holdDone;

    assign anyReq     = inmenuSync_q | (|pause_req_i);
    assign vbRise     = vblank_i & ~vblank_q;
    assign timeoutHit = (wcnt_q == WCNT_MAX);
    assign holdDone   = (hcnt_q == HCNT_MAX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (anyReq) state_d = ARM;
            ARM:     if (!anyReq) state_d = RUN;
                     else if (vbRise || timeoutHit) state_d = PAUSED;
            PAUSED:  if (!anyReq && holdDone) state_d = RELEASE;
            RELEASE: if (anyReq) state_d = PAUSED;
                     else if (vbRise || timeoutHit) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // The wait counter restarts whenever ARM or RELEASE is freshly entered.
    always_comb begin
        wcnt_d = '0;
        if ((state_d == ARM || state_d == RELEASE) && state_d == state_q)
            wcnt_d = wcnt_q + 1'b1;
    end

    // Hold counter is kept across RELEASE->PAUSED so a bounce does not restart the minimum.
    always_comb begin
        hcnt_d = hcnt_q;
        if (state_q == ARM && state_d == PAUSED)
            hcnt_d = '0;
        else if (state_q == PAUSED && !holdDone)
            hcnt_d = hcnt_q + 1'b1;
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= RUN;
            inmenuMeta_q <= 1'b0;
            inmenuSync_q <= 1'b0;
            vblank_q     <= 1'b0;
            wcnt_q       <= '0;
            hcnt_q       <= '0;
            pauseCore_q  <= 1'b0;
            pauseAck_q   <= '0;
        end else begin
            state_q      <= state_d;
            inmenuMeta_q <= os_inmenu_i;
            inmenuSync_q <= inmenuMeta_q;
            vblank_q     <= vblank_i;
            wcnt_q       <= wcnt_d;
            hcnt_q       <= hcnt_d;
            pauseCore_q  <= (state_d == PAUSED) || (state_d == RELEASE);
            pauseAck_q   <= (state_d == PAUSED) ? pause_req_i : '0;
        end
    end

    assign pause_core_o  = pauseCore_q;
    assign pause_ack_o   = pauseAck_q;
    assign pause_state_o = state_q;

endmodule

// File: tb/tb_pause_sched.sv
// Scoreboard bench for pause_sched: stimulus queues the expected output changes with their
// cycle numbers, and a monitor pops and compares on every change of the DUT outputs.
module tb_pause_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       osInmenu = 1'b0;
    logic       vblank = 1'b0;
    logic [3:0] pauseReq = 4'b0000;
    logic       pauseCore;
    logic [3:0] pauseAck;
    logic [1:0] pauseState;

    pause_sched #(
        .NUM_REQ       (4),
        .TIMEOUT_CYC   (100),
        .MIN_PAUSE_CYC (16)
    ) dut (
        .clk_sys_i     (clk),
        .reset_i       (reset),
        .os_inmenu_i   (osInmenu),
        .vblank_i      (vblank),
        .pause_req_i   (pauseReq),
        .pause_core_o  (pauseCore),
        .pause_ack_o   (pauseAck),
        .pause_state_o (pauseState)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [6:0] val;
    } exp_t;

    exp_t       expQ[$];
    int         nChecks = 0;
    int         nFails = 0;
    logic [6:0] curVal;
    logic [6:0] prevVal = 7'd0;

    assign curVal = {pauseCore, pauseAck, pauseState};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expectAt(input int c, input logic core, input logic [3:0] ack, input logic [1:0] st);
        exp_t e;
        e.cyc = c;
        e.val = {core, ack, st};
        expQ.push_back(e);
    endtask

    task automatic goCycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic vb, input logic os);
        pauseReq = req;
        vblank   = vb;
        osInmenu = os;
    endtask

    // Monitor: every change of {core, ack, state} outside reset must match the next expected event.
    always @(negedge clk) begin
        if (reset) begin
            prevVal = curVal;
        end else if (curVal !== prevVal) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected change at cyc %0d: got %b, expected no change from %b",
                         cyc, curVal, prevVal);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput($sformatf("event value (exp cyc %0d)", e.cyc), 32'(curVal), 32'(e.val));
                checkOutput($sformatf("event cycle (val %b)", e.val), 32'(cyc), 32'(e.cyc));
            end
            prevVal = curVal;
        end
    end

    initial begin
        int b;

        goCycle(3);
        checkOutput("reset pause_core", 32'(pauseCore), 32'd0);
        checkOutput("reset pause_ack", 32'(pauseAck), 32'd0);
        checkOutput("reset pause_state", 32'(pauseState), 32'd0);
        reset = 1'b0;

        // Request via module 0, vblank entry, a second joiner, then release on a later vblank.
        goCycle(5);
        b = cyc;
        expectAt(b + 11,  1'b0, 4'b0000, 2'd1);
        expectAt(b + 51,  1'b1, 4'b0001, 2'd2);
        expectAt(b + 56,  1'b1, 4'b0011, 2'd2);
        expectAt(b + 59,  1'b1, 4'b0001, 2'd2);
        expectAt(b + 61,  1'b1, 4'b0000, 2'd2);
        expectAt(b + 68,  1'b1, 4'b0000, 2'd3);
        expectAt(b + 121, 1'b0, 4'b0000, 2'd0);
        goCycle(b + 10);  applyStimulus(4'b0001, 1'b0, 1'b0);
        goCycle(b + 50);  applyStimulus(4'b0001, 1'b1, 1'b0);
        goCycle(b + 52);  applyStimulus(4'b0001, 1'b0, 1'b0);
        goCycle(b + 55);  applyStimulus(4'b0011, 1'b0, 1'b0);
        goCycle(b + 58);  applyStimulus(4'b0001, 1'b0, 1'b0);
        goCycle(b + 60);  applyStimulus(4'b0000, 1'b0, 1'b0);
        goCycle(b + 120); applyStimulus(4'b0000, 1'b1, 1'b0);
        goCycle(b + 122); applyStimulus(4'b0000, 1'b0, 1'b0);
        goCycle(b + 125);

        // Menu request with no vblank at all: both transitions are forced by the timeout.
        b = cyc;
        expectAt(b + 5,   1'b0, 4'b0000, 2'd1);
        expectAt(b + 105, 1'b1, 4'b0000, 2'd2);
        expectAt(b + 122, 1'b1, 4'b0000, 2'd3);
        expectAt(b + 222, 1'b0, 4'b0000, 2'd0);
        goCycle(b + 2);   applyStimulus(4'b0000, 1'b0, 1'b1);
        goCycle(b + 110); applyStimulus(4'b0000, 1'b0, 1'b0);
        goCycle(b + 225);

        // Request withdrawn inside ARM: back to RUN, never paused or acked.
        b = cyc;
        expectAt(b + 3, 1'b0, 4'b0000, 2'd1);
        expectAt(b + 8, 1'b0, 4'b0000, 2'd0);
        goCycle(b + 2);  applyStimulus(4'b0010, 1'b0, 1'b0);
        goCycle(b + 7);  applyStimulus(4'b0000, 1'b0, 1'b0);
        goCycle(b + 12);

        // Short request, minimum hold, then re-request together with vblank during RELEASE.
        b = cyc;
        expectAt(b + 3,  1'b0, 4'b0000, 2'd1);
        expectAt(b + 6,  1'b1, 4'b0100, 2'd2);
        expectAt(b + 7,  1'b1, 4'b0000, 2'd2);
        expectAt(b + 23, 1'b1, 4'b0000, 2'd3);
        expectAt(b + 31, 1'b1, 4'b1000, 2'd2);
        goCycle(b + 2);  applyStimulus(4'b0100, 1'b0, 1'b0);
        goCycle(b + 5);  applyStimulus(4'b0100, 1'b1, 1'b0);
        goCycle(b + 6);  applyStimulus(4'b0000, 1'b1, 1'b0);
        goCycle(b + 7);  applyStimulus(4'b0000, 1'b0, 1'b0);
        goCycle(b + 30); applyStimulus(4'b1000, 1'b1, 1'b0);
        goCycle(b + 32); applyStimulus(4'b1000, 1'b0, 1'b0);

        // Reset while paused must clear outputs before the next clock edge.
        goCycle(b + 40);
        reset = 1'b1;
        #1;
        checkOutput("async reset pause_core", 32'(pauseCore), 32'd0);
        checkOutput("async reset pause_ack", 32'(pauseAck), 32'd0);
        checkOutput("async reset pause_state", 32'(pauseState), 32'd0);
        goCycle(b + 43); applyStimulus(4'b0000, 1'b0, 1'b0);
        goCycle(b + 45); reset = 1'b0;
        goCycle(b + 50);

        checkOutput("pending expected events", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
